// File: rtl/lcd_pkg.sv
// Shared constants, state encoding and helpers for the character-LCD frame sequencer.
// Command bytes follow the HD44780 instruction set.
package lcd_pkg;

  localparam logic [7:0] LCD_CMD_FUNCSET = 8'h38;
  localparam logic [7:0] LCD_CMD_DISPON  = 8'h0C;
  localparam logic [7:0] LCD_CMD_CLEAR   = 8'h01;
  localparam logic [7:0] LCD_CMD_ENTRY   = 8'h06;
  localparam logic [7:0] LCD_CMD_SETADDR = 8'h80;

  localparam int LCD_INIT_LEN = 4;

  // DDRAM start address of each display line, index = row
  localparam logic [3:0][7:0] LCD_ROW_BASE = {8'h54, 8'h14, 8'h40, 8'h00};

  typedef enum logic [2:0] {
    ST_INIT = 3'd0,
    ST_SEND = 3'd1,
    ST_WAIT = 3'd2,
    ST_GAP  = 3'd3,
    ST_NEXT = 3'd4,
    ST_SCAN = 3'd5,
    ST_IDLE = 3'd6
  } lcd_st_t;

  function automatic logic [7:0] row_base(input logic [1:0] row);
    return LCD_ROW_BASE[row];
  endfunction

  function automatic logic [7:0] init_cmd(input logic [1:0] step);
    logic [7:0] cmd;
    case (step)
      2'd0:    cmd = LCD_CMD_FUNCSET;
      2'd1:    cmd = LCD_CMD_DISPON;
      2'd2:    cmd = LCD_CMD_CLEAR;
      2'd3:    cmd = LCD_CMD_ENTRY;
      default: cmd = LCD_CMD_ENTRY;
    endcase
    return cmd;
  endfunction

endpackage

// File: rtl/lcd_frame_refresh_char_buf.sv
// ROWS x COLS character store: one synchronous write port, one combinational read port.
// Cells are addressed row*COLS+col and reset to FILL_CHAR.
module lcd_char_buf
  import lcd_pkg::*;
#(
  parameter int          ROWS      = 2,
  parameter int          COLS      = 16,
  parameter logic [7:0]  FILL_CHAR = 8'h20
) (
  input  logic       iCLK,
  input  logic       iRST_N,
  input  logic       wr_en,
  input  logic [1:0] wr_row,
  input  logic [5:0] wr_col,
  input  logic [7:0] wr_char,
  input  logic [1:0] rd_row,
  input  logic [5:0] rd_col,
  output logic [7:0] rd_char
);

  localparam int DEPTH = ROWS * COLS;
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [7:0]    mem_r [DEPTH];
  logic [AW-1:0] wr_idx_s;
  logic [AW-1:0] rd_idx_s;

  assign wr_idx_s = AW'(int'(wr_row) * COLS + int'(wr_col));
  assign rd_idx_s = AW'(int'(rd_row) * COLS + int'(rd_col));
  assign rd_char  = mem_r[rd_idx_s];

  // Cell storage; callers only assert wr_en for in-range coordinates
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= FILL_CHAR;
      end
    end else if (wr_en) begin
      mem_r[wr_idx_s] <= wr_char;
    end
  end

endmodule

// File: rtl/lcd_frame_refresh.sv
// Character-LCD sequencer: runs the controller init once, paints every row, then
// repaints only rows dirtied by host writes, via the LCD_Controller start/done handshake.
module lcd_frame_refresh
  import lcd_pkg::*;
#(
  parameter int          ROWS       = 2,
  parameter int          COLS       = 16,
  parameter int          GAP_CYCLES = 262142,
  parameter logic [7:0]  FILL_CHAR  = 8'h20
) (
  input  logic       iCLK,
  input  logic       iRST_N,
  input  logic       wr_en,
  input  logic [1:0] wr_row,
  input  logic [5:0] wr_col,
  input  logic [7:0] wr_char,
  output logic [7:0] ctl_data,
  output logic       ctl_rs,
  output logic       ctl_start,
  input  logic       ctl_done,
  output logic       init_done,
  output logic       busy
);

  localparam int             GW       = $clog2(GAP_CYCLES + 1);
  localparam logic [GW-1:0]  GAP_LAST = GW'(GAP_CYCLES - 1);
  localparam logic [5:0]     COL_LAST = 6'(COLS - 1);
  localparam logic [1:0]     STEP_LAST = 2'(LCD_INIT_LEN - 1);

  lcd_st_t         state_r, state_nxt_s;
  logic [1:0]      step_r, step_nxt_s;
  logic [1:0]      row_r, row_nxt_s;
  logic [5:0]      col_r, col_nxt_s;
  logic            addr_phase_r, addr_phase_nxt_s;
  logic [GW-1:0]   gap_r, gap_nxt_s;
  logic [ROWS-1:0] dirty_r, dirty_nxt_s, dirty_set_s, dirty_clr_s;
  logic [7:0]      ctl_data_r, ctl_data_nxt_s;
  logic            ctl_rs_r, ctl_rs_nxt_s;
  logic            ctl_start_r, ctl_start_nxt_s;
  logic            init_done_r, init_done_nxt_s;
  logic            busy_r;

  logic            wr_ok_s;
  logic [7:0]      rd_char_s;
  logic [7:0]      xfer_byte_s;
  logic            xfer_rs_s;
  logic [1:0]      scan_idx_s;
  logic            scan_hit_s;

  assign wr_ok_s = wr_en && ({1'b0, wr_row} < 3'(ROWS)) && (wr_col < 6'(COLS));

  lcd_char_buf #(
    .ROWS      (ROWS),
    .COLS      (COLS),
    .FILL_CHAR (FILL_CHAR)
  ) u_buf (
    .iCLK    (iCLK),
    .iRST_N  (iRST_N),
    .wr_en   (wr_ok_s),
    .wr_row  (wr_row),
    .wr_col  (wr_col),
    .wr_char (wr_char),
    .rd_row  (row_r),
    .rd_col  (col_r),
    .rd_char (rd_char_s)
  );

  // Byte to hand to the controller for the current step of the sequence
  always_comb begin
    if (!init_done_r) begin
      xfer_byte_s = init_cmd(step_r);
      xfer_rs_s   = 1'b0;
    end else if (addr_phase_r) begin
      xfer_byte_s = LCD_CMD_SETADDR | row_base(row_r);
      xfer_rs_s   = 1'b0;
    end else begin
      xfer_byte_s = rd_char_s;
      xfer_rs_s   = 1'b1;
    end
  end

  // Lowest-numbered dirty row: walk downwards so the smallest index is assigned last
  always_comb begin
    scan_idx_s = 2'd0;
    for (int i = ROWS - 1; i >= 0; i--) begin
      scan_idx_s = dirty_r[i] ? 2'(i) : scan_idx_s;
    end
  end

  assign scan_hit_s  = |dirty_r;
  assign dirty_set_s = wr_ok_s ? (ROWS'(1) << wr_row) : '0;
  // A host write landing on the row being claimed keeps it dirty
  assign dirty_nxt_s = (dirty_r & ~dirty_clr_s) | dirty_set_s;

  // Sequencer next-state and output decode
  always_comb begin
    state_nxt_s      = state_r;
    step_nxt_s       = step_r;
    row_nxt_s        = row_r;
    col_nxt_s        = col_r;
    addr_phase_nxt_s = addr_phase_r;
    gap_nxt_s        = gap_r;
    ctl_data_nxt_s   = ctl_data_r;
    ctl_rs_nxt_s     = ctl_rs_r;
    ctl_start_nxt_s  = ctl_start_r;
    init_done_nxt_s  = init_done_r;
    dirty_clr_s      = '0;
    case (state_r)
      ST_INIT: begin
        state_nxt_s = ST_SEND;
      end
      ST_SEND: begin
        ctl_data_nxt_s  = xfer_byte_s;
        ctl_rs_nxt_s    = xfer_rs_s;
        ctl_start_nxt_s = 1'b1;
        state_nxt_s     = ST_WAIT;
      end
      ST_WAIT: begin
        if (ctl_done) begin
          ctl_start_nxt_s = 1'b0;
          state_nxt_s     = ST_GAP;
        end else begin
          state_nxt_s     = ST_WAIT;
        end
      end
      ST_GAP: begin
        if (gap_r == GAP_LAST) begin
          gap_nxt_s   = '0;
          state_nxt_s = ST_NEXT;
        end else begin
          gap_nxt_s   = gap_r + 1'b1;
        end
      end
      ST_NEXT: begin
        if (!init_done_r) begin
          if (step_r == STEP_LAST) begin
            init_done_nxt_s = 1'b1;
            state_nxt_s     = ST_SCAN;
          end else begin
            step_nxt_s      = step_r + 2'd1;
            state_nxt_s     = ST_SEND;
          end
        end else if (addr_phase_r) begin
          addr_phase_nxt_s = 1'b0;
          col_nxt_s        = 6'd0;
          state_nxt_s      = ST_SEND;
        end else if (col_r == COL_LAST) begin
          state_nxt_s      = ST_SCAN;
        end else begin
          col_nxt_s        = col_r + 6'd1;
          state_nxt_s      = ST_SEND;
        end
      end
      ST_SCAN: begin
        if (scan_hit_s) begin
          dirty_clr_s      = ROWS'(1) << scan_idx_s;
          row_nxt_s        = scan_idx_s;
          addr_phase_nxt_s = 1'b1;
          state_nxt_s      = ST_SEND;
        end else begin
          state_nxt_s      = ST_IDLE;
        end
      end
      ST_IDLE: begin
        if (scan_hit_s) begin
          state_nxt_s = ST_SCAN;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      default: begin
        state_nxt_s = ST_INIT;
      end
    endcase
  end

  // State and registered outputs; reset drops ctl_start immediately and restarts init
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state_r      <= ST_INIT;
      step_r       <= 2'd0;
      row_r        <= 2'd0;
      col_r        <= 6'd0;
      addr_phase_r <= 1'b0;
      gap_r        <= '0;
      dirty_r      <= '1;
      ctl_data_r   <= 8'h00;
      ctl_rs_r     <= 1'b0;
      ctl_start_r  <= 1'b0;
      init_done_r  <= 1'b0;
      busy_r       <= 1'b0;
    end else begin
      state_r      <= state_nxt_s;
      step_r       <= step_nxt_s;
      row_r        <= row_nxt_s;
      col_r        <= col_nxt_s;
      addr_phase_r <= addr_phase_nxt_s;
      gap_r        <= gap_nxt_s;
      dirty_r      <= dirty_nxt_s;
      ctl_data_r   <= ctl_data_nxt_s;
      ctl_rs_r     <= ctl_rs_nxt_s;
      ctl_start_r  <= ctl_start_nxt_s;
      init_done_r  <= init_done_nxt_s;
      busy_r       <= (state_nxt_s != ST_IDLE);
    end
  end

  assign ctl_data  = ctl_data_r;
  assign ctl_rs    = ctl_rs_r;
  assign ctl_start = ctl_start_r;
  assign init_done = init_done_r;
  assign busy      = busy_r;

endmodule
